// File: rtl/div_sequencial.sv
// rtl/div_sequencial.sv - multicycle signed restoring divider (lo=quotient, hi=remainder)
module div_sequencial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic             divisor_zero;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1), which is exact as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  assign divisor_zero = (divisor == '0);

  // One restoring step: the remainder stays below |divisor| <= 2^(WIDTH-1), so the
  // shifted value fits in WIDTH+1 bits and the trial's top bit is a clean sign.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvsr_q};

  // Sign restoration: quotient truncates toward zero, remainder follows the dividend.
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE, so it is never queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = divisor_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; done and div_zero are single-cycle because DONE lasts one cycle
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    div_zero = (state_q == S_DONE) && dz_q;
    lo       = lo_q;
    hi       = hi_q;
  end

  // Datapath next-state: operand capture, shift-subtract iteration, result write-back
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dz_d = divisor_zero;
          if (!divisor_zero) begin
            quo_d     = mag(dividendo);
            dvsr_d    = mag(divisor);
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = dividendo[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividendo[WIDTH-1];
          end
        end
      end
      S_RUN: begin
        rem_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        lo_d = quo_fix;
        hi_d = rem_fix;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
    end
  end

endmodule

// File: tb/tb_div_sequencial.sv
// tb/tb_div_sequencial.sv - randomized self-checking bench for div_sequencial
module tb_div_sequencial;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what lo/hi must hold after the last completed operation
  logic [W-1:0] exp_lo = '0;
  logic [W-1:0] exp_hi = '0;

  div_sequencial #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one operation starting just after a negedge. Optionally pulses a second
  // start (9/3) while busy, which must be ignored. Operands are scrambled after
  // the accepted start to show they are not re-sampled.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    longint sa, sb, q, r;
    int     n;
    int     exp_lat;
    logic   exp_dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      exp_dz  = 1'b1;
      exp_lat = 1;
    end else begin
      q       = sa / sb;
      r       = sa % sb;
      exp_lo  = q[W-1:0];
      exp_hi  = r[W-1:0];
      exp_dz  = 1'b0;
      exp_lat = W + 2;
    end
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    dividendo = $urandom;
    divisor   = $urandom;
    n = 1;
    while (!done && n < 3 * W) begin
      if (inject && n == 5) begin
        start     = 1'b1;
        dividendo = 32'd9;
        divisor   = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_at_done", {31'd0, busy}, 32'd1);
    check("lo", lo, exp_lo);
    check("hi", hi, exp_hi);
    check("div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset     = 1'b1;
    start     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_lo", lo, '0);
    check("rst_hi", hi, '0);
    check("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: signs, divide by zero, overflow, small and zero dividends
    run_op(32'd7, 32'd2, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(-32'sd7, 32'd2, 1'b0);
    run_op(32'd7, -32'sd2, 1'b0);
    run_op(-32'sd7, -32'sd2, 1'b0);
    run_op(MIN_NEG, 32'hFFFF_FFFF, 1'b0);
    run_op(MIN_NEG, 32'd1, 1'b0);
    run_op(32'd3, 32'd100, 1'b0);
    run_op(-32'sd3, 32'd100, 1'b0);
    run_op(32'd0, -32'sd5, 1'b0);
    run_op(32'd100, 32'd7, 1'b1);

    // Reset in the middle of RUN aborts with no done pulse
    dividendo = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_lo", lo, '0);
    check("midrst_hi", hi, '0);
    check("midrst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    exp_lo = '0;
    exp_hi = '0;
    repeat (2) @(negedge clk);
    check("midrst_no_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) check("spurious_done", {31'd0, done}, 32'd0);
    end
    run_op(32'd9, 32'd3, 1'b0);

    // Randomized operations, back-to-back
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = MIN_NEG;
      if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 20)) - 32'd10;
      run_op(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
